// File: rtl/key_expansion_if.sv
// Port bundle for the AES-128 key schedule: start/key load, status, round-key read port and S-box word port.
// The optional streaming outputs exist only when KEY_EXPANSION_STREAM_EN is defined.
interface key_expansion_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic [31:0]  sbox_word_out;
  logic [31:0]  sbox_word_in;
`ifdef KEY_EXPANSION_STREAM_EN
  logic         rk_valid;
  logic [3:0]   rk_out_idx;
  logic [127:0] rk_out;
`endif

  modport slave (
    input  start, key_in, rk_idx, sbox_word_in,
`ifdef KEY_EXPANSION_STREAM_EN
    output rk_valid, rk_out_idx, rk_out,
`endif
    output busy, done, rk_data, sbox_word_out
  );

  modport master (
    output start, key_in, rk_idx, sbox_word_in,
`ifdef KEY_EXPANSION_STREAM_EN
    input  rk_valid, rk_out_idx, rk_out,
`endif
    input  busy, done, rk_data, sbox_word_out
  );
endinterface

// File: rtl/key_expansion.sv
// AES-128 key schedule: one 32-bit word per clock via a shared external S-box, 11 round keys held in a word file.
// Optional KEY_EXPANSION_STREAM_EN adds registered rk_valid/rk_out_idx/rk_out streaming outputs.
module key_expansion #(
  parameter int ROUNDS = 10,
  parameter int KEY_W  = 128
) (
  input logic           clk,
  input logic           rst,
  key_expansion_if.slave kx
);
  localparam int NK     = KEY_W / 32;
  localparam int NWORDS = NK * (ROUNDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] w_q [NWORDS];

  logic        load_key;
  logic        wr_en;
  logic        rot_word;
  logic [31:0] prev_word;
  logic [31:0] temp_word;
  logic [31:0] new_word;
  logic [5:0]  rd_base;

  // Datapath is evaluated every cycle; it only matters while wr_en is set.
  assign prev_word = w_q[i_q - 6'd1];
  assign rot_word  = (i_q[1:0] == 2'd0);
  assign temp_word = rot_word ? (kx.sbox_word_in ^ {rcon_q, 24'h0}) : prev_word;
  assign new_word  = w_q[i_q - 6'd4] ^ temp_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= 6'd4;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      rcon_q  <= rcon_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    i_d              = i_q;
    rcon_d           = rcon_q;
    load_key         = 1'b0;
    wr_en            = 1'b0;
    kx.sbox_word_out = 32'h0;
    kx.busy          = 1'b0;
    kx.done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (kx.start) begin
          load_key = 1'b1;
          i_d      = 6'd4;
          rcon_d   = 8'h01;
          state_d  = S_EXPAND;
        end
      end
      S_EXPAND: begin
        kx.busy = 1'b1;
        wr_en   = 1'b1;
        i_d     = i_q + 6'd1;
        if (rot_word) begin
          kx.sbox_word_out = {prev_word[23:0], prev_word[31:24]};
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (i_q == 6'(NWORDS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        kx.done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Word file: needs a full reset, so it is kept in flops rather than block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NWORDS; k++) w_q[k] <= '0;
    end else begin
      if (load_key) begin
        for (int k = 0; k < NK; k++) w_q[k] <= kx.key_in[KEY_W-1-32*k -: 32];
      end
      if (wr_en) w_q[i_q] <= new_word;
    end
  end

  always_comb begin
    kx.rk_data = '0;
    rd_base    = {kx.rk_idx, 2'b00};
    if (kx.rk_idx <= 4'(ROUNDS)) begin
      kx.rk_data = {w_q[rd_base], w_q[rd_base + 6'd1], w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end
  end

`ifdef KEY_EXPANSION_STREAM_EN
  logic         rk_valid_q;
  logic [3:0]   rk_out_idx_q;
  logic [127:0] rk_out_q;

  // A round key completes either on the key load or when its last word (i%4==3) is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_valid_q   <= 1'b0;
      rk_out_idx_q <= 4'd0;
      rk_out_q     <= '0;
    end else begin
      rk_valid_q   <= 1'b0;
      rk_out_idx_q <= 4'd0;
      rk_out_q     <= '0;
      if (load_key) begin
        rk_valid_q <= 1'b1;
        rk_out_q   <= kx.key_in;
      end else if (wr_en && (i_q[1:0] == 2'd3)) begin
        rk_valid_q   <= 1'b1;
        rk_out_idx_q <= i_q[5:2];
        rk_out_q     <= {w_q[i_q - 6'd3], w_q[i_q - 6'd2], prev_word, new_word};
      end
    end
  end

  assign kx.rk_valid   = rk_valid_q;
  assign kx.rk_out_idx = rk_out_idx_q;
  assign kx.rk_out     = rk_out_q;
`endif
endmodule

// File: tb/tb_key_expansion.sv
// Self-checking bench for key_expansion: S-box built from GF(2^8) arithmetic, FIPS-197 style expansion model.
module tb_key_expansion;
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic clk;
  logic rst;
  key_expansion_if kx();

  key_expansion dut (.clk(clk), .rst(rst), .kx(kx.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit auto_idx = 1'b1;
  int n_pulse = 0;
  logic [127:0] last10;

  logic [7:0]  sbox [256];
  logic [31:0] exp_w [44];
  logic [31:0] cur [44];
  bit          m_active = 1'b0;
  int          m_p = 0;

  assign kx.sbox_word_in = {sbox[kx.sbox_word_out[31:24]], sbox[kx.sbox_word_out[23:16]],
                            sbox[kx.sbox_word_out[15:8]], sbox[kx.sbox_word_out[7:0]]};

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] d = {v, v};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    case (r)
      1: return 8'h01;  2: return 8'h02;  3: return 8'h04;  4: return 8'h08;  5: return 8'h10;
      6: return 8'h20;  7: return 8'h40;  8: return 8'h80;  9: return 8'h1b;  default: return 8'h36;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] v);
    return {sbox[v[31:24]], sbox[v[23:16]], sbox[v[15:8]], sbox[v[7:0]]};
  endfunction

  task automatic do_expand(input logic [127:0] key);
    logic [31:0] t;
    for (int j = 0; j < 4; j++) exp_w[j] = key[127-32*j -: 32];
    for (int j = 4; j < 44; j++) begin
      t = exp_w[j-1];
      if (j % 4 == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon_of(j/4), 24'h0};
      exp_w[j] = exp_w[j-4] ^ t;
    end
  endtask

  function automatic logic [127:0] row(input int r);
    return {cur[4*r], cur[4*r+1], cur[4*r+2], cur[4*r+3]};
  endfunction

  // Model: word j of the schedule becomes visible j-3 edges after the accepted start.
  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_p = 0;
      for (int k = 0; k < 44; k++) cur[k] = 32'h0;
    end else if (!m_active) begin
      if (kx.start) begin
        do_expand(kx.key_in);
        for (int k = 0; k < 4; k++) cur[k] = exp_w[k];
        m_active = 1'b1;
        m_p = 0;
      end
    end else if (m_p < 40) begin
      cur[m_p+4] = exp_w[m_p+4];
      m_p++;
    end else begin
      m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [31:0] pw;
      pw = (m_p + 3 < 44) ? cur[m_p+3] : 32'h0;
      chk("busy", kx.busy, m_active && m_p < 40);
      chk("done", kx.done, m_active && m_p == 40);
      chk("sbox_out", kx.sbox_word_out,
          (m_active && m_p < 40 && m_p % 4 == 0) ? {pw[23:0], pw[31:24]} : 32'h0);
      chk("rk_data", kx.rk_data, (kx.rk_idx <= 4'd10) ? row(int'(kx.rk_idx)) : 128'h0);
`ifdef KEY_EXPANSION_STREAM_EN
      chk("rk_valid", kx.rk_valid, m_active && m_p % 4 == 0);
      chk("rk_out_idx", kx.rk_out_idx, (m_active && m_p % 4 == 0) ? 4'(m_p / 4) : 4'd0);
      chk("rk_out", kx.rk_out, (m_active && m_p % 4 == 0) ? row(m_p / 4) : 128'h0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (auto_idx) kx.rk_idx = kx.rk_idx + 4'd1;
`ifdef KEY_EXPANSION_STREAM_EN
    if (kx.rk_valid) begin
      chk("stream_seq", kx.rk_out_idx, 4'(n_pulse));
      if (kx.rk_out_idx == 4'd10) last10 = kx.rk_out;
      n_pulse++;
    end
`endif
  endtask

  task automatic start_key(input logic [127:0] k);
    n_pulse = 0;
    auto_idx = 1'b1;
    kx.key_in = k;
    kx.start = 1'b1;
    tick();
    kx.start = 1'b0;
  endtask

  task automatic run_to_done(input bit pester, output int cyc);
    cyc = 1;
    while (!kx.done && cyc < 200) begin
      kx.start = pester && (cyc % 3 == 0);
      if (pester) kx.key_in = FIPS_KEY;
      tick();
      cyc++;
    end
    kx.start = 1'b0;
    if (!kx.done) chk("done_timeout", 128'h0, 128'h1);
  endtask

  task automatic peek(input string name, input int idx, input logic [127:0] exp);
    auto_idx = 1'b0;
    kx.rk_idx = 4'(idx);
    #1;
    chk(name, kx.rk_data, exp);
  endtask

  initial begin
    int cyc;
    int ndone;
    rst = 1'b1;
    kx.start = 1'b0;
    kx.key_in = '0;
    kx.rk_idx = 4'd0;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    chk("sbox_00", {120'h0, sbox[0]}, 128'h63);
    chk("sbox_53", {120'h0, sbox[8'h53]}, 128'hed);

    tick();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (16) tick();

    // FIPS-197 key
    start_key(FIPS_KEY);
    run_to_done(1'b0, cyc);
    chk("latency_fips", 128'(cyc), 128'd41);
    chk("model_rk1", {exp_w[4], exp_w[5], exp_w[6], exp_w[7]}, FIPS_RK1);
    peek("fips_rk1", 1, FIPS_RK1);
    peek("fips_rk10", 10, FIPS_RK10);
    peek("fips_rk0", 0, FIPS_KEY);
`ifdef KEY_EXPANSION_STREAM_EN
    chk("stream_pulses", 128'(n_pulse), 128'd11);
    chk("stream_rk10", last10, FIPS_RK10);
`endif
    repeat (3) tick();

    // All-zero key, with start pestered using a different key while busy
    start_key(128'h0);
    run_to_done(1'b1, cyc);
    chk("latency_zero", 128'(cyc), 128'd41);
    kx.key_in = FIPS_KEY;
    kx.start = 1'b1;
    tick();
    kx.start = 1'b0;
    chk("done_start_ignored", kx.busy, 1'b0);
    peek("zero_rk1", 1, ZERO_RK1);
    peek("zero_rk10", 10, ZERO_RK10);
    for (int k = 11; k < 16; k++) peek("idx_oob", k, 128'h0);
    tick();

    // Reset in the middle of an expansion
    start_key(FIPS_KEY);
    repeat (19) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", kx.busy, 1'b0);
    ndone = 0;
    for (int k = 0; k < 16; k++) begin
      peek("abort_rk", k, 128'h0);
      tick();
      if (kx.done) ndone++;
    end
    repeat (30) begin
      tick();
      if (kx.done) ndone++;
    end
    chk("abort_no_done", 128'(ndone), 128'd0);

    start_key(FIPS_KEY);
    run_to_done(1'b0, cyc);
    chk("latency_after_abort", 128'(cyc), 128'd41);
    peek("after_abort_rk10", 10, FIPS_RK10);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t exp=finish", $time);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/key_expansion.md
# key_expansion

AES-128 key schedule generator. Expands a 128-bit cipher key into the 11 round keys that the `addRoundKey` XOR stage consumes. Computes one 32-bit word per clock through an external shared S-box word port, stores all round keys in an internal register file, and exposes them through a combinational read port indexed by round number.

## Interface

Parameters:
- `ROUNDS`, 10: number of cipher rounds. The key file holds `ROUNDS+1` entries. Only 10 (AES-128) is supported.
- `KEY_W`, 128: key and round-key width. Fixed at 128.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `start`  in  1  begin expansion of `key_in`; sampled only in IDLE.
- `key_in`  in  128  cipher key; sampled on the accepted `start` cycle.
- `busy`  out  1  high while expansion is in progress.
- `done`  out  1  single-cycle pulse when all round keys are valid.
- `rk_idx`  in  4  round-key read index, 0..10.
- `rk_data`  out  128  round key `rk_idx` (combinational read).
- `sbox_word_out`  out  32  word sent to the shared S-box (four bytes, each substituted independently).
- `sbox_word_in`  in  32  S-box result for `sbox_word_out`; combinational, same cycle.

## Operation

- Word `w[j]` occupies bits `[127-32*(j%4) -: 32]` of round key `rk[j/4]`, so `w[4r]` is the most significant word.
- The FSM has three states:
  - IDLE: `start` loads `key_in` into `rk[0]`, sets word counter `i`=4 and `rcon`=8'h01, then goes to EXPAND.
  - EXPAND: computes `w[i]` each cycle, then increments `i`. After `i`=43 it goes to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Word computation in EXPAND:
  - When `i%4==0`: `temp = sbox_word_in ^ {rcon,24'h0}`, where `sbox_word_out = RotWord(w[i-1]) = {w[i-1][23:0], w[i-1][31:24]}`. After this word is written, `rcon` updates to `xtime(rcon)`, i.e. `{rcon[6:0],1'b0} ^ (rcon[7] ? 8'h1b : 8'h00)`.
  - Otherwise: `temp = w[i-1]`.
  - In both cases `w[i] = w[i-4] ^ temp`.
- The `rcon` sequence over the 10 rounds is 01,02,04,08,10,20,40,80,1b,36.
- `sbox_word_out` is 32'h0 outside EXPAND and on cycles where `i%4 != 0`.
- `start` is ignored in EXPAND and DONE. There is no restart or queuing.
- `rk_idx` greater than 10 returns 128'h0.
- Round keys stay valid after DONE until the next accepted `start` or `rst`.
- A new `start` overwrites `rk[0]` immediately. Entries 1..10 are stale until they are rewritten.

## Timing

- Reset values:
  - state = IDLE
  - `busy`=0, `done`=0
  - `sbox_word_out`=0
  - all `rk[*]`=0, so `rk_data`=0
  - `i`=4, `rcon`=8'h01
  - with the macro enabled: `rk_valid`=0, `rk_out_idx`=0, `rk_out`=0
- For `start` accepted at edge T:
  - `rk[0]` is readable after T.
  - `busy`=1 from T+1 through T+40.
  - `rk[r]` is complete after edge T+4r, for r=1..10.
  - `done`=1 during the cycle after edge T+40, with `busy`=0 in that cycle.
- Total latency from `start` to `done` is 41 cycles.
- `rk_data` reflects a register write in the cycle following that write.
- Reset mid-expansion aborts the operation:
  - the next cycle is IDLE with all registers at their reset values
  - no `done` pulse is produced
- `rst` and `start` asserted together: `rst` wins and `start` is dropped.
- `start` during the DONE cycle is ignored.

## Configuration

- `KEY_EXPANSION_STREAM_EN` defined: adds three outputs so a pipelined cipher can consume keys without polling the read port.
  - `rk_valid` (out, 1): pulses for one cycle each time a round key completes, including `rk[0]` on the cycle after `start`. That gives 11 pulses per expansion.
  - `rk_out_idx` (out, 4): index of the completed round key.
  - `rk_out` (out, 128): the completed round key.
  - All three are registered and are 0 when `rk_valid` is 0.
- `KEY_EXPANSION_STREAM_EN` undefined: these three ports and their logic are absent. All other behaviour is identical.

## Test plan

- FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, then `start` → `done` exactly 41 cycles later.
  - `rk[1]` = `a0fafe1788542cb123a339392a6c7605`
  - `rk[10]` = `d014f9a8c9ee2589e13f0cc8b6630ca6`
- All-zero key → `rk[1]` = `62636363626363636263636362636363`, `rk[10]` = `b4ef5bcb3e92e21123e951cf6f8f188e`.
- `rst` asserted at cycle 20 of an expansion → next cycle `busy`=0, `rk_data`=0 for every index, no `done` pulse. A following `start` with the FIPS key still yields the correct `rk[10]`.
- `start` pulsed repeatedly during `busy` with a different key → ignored; the results match the first key.
- `rk_idx`=11..15 → `rk_data`=0.
- With `KEY_EXPANSION_STREAM_EN` (FIPS key):
  - 11 `rk_valid` pulses, with `rk_out_idx` running 0..10 at spacing 1,4,4,…
  - the pulse with `rk_out_idx`=10 carries `d014f9a8c9ee2589e13f0cc8b6630ca6`.
